fpu_stack_sequencer: RTL
========================

// Module: fpu_stack_sequencer
// PURPOSE
//  Parametrised x87 register-stack/timing model behind the FPU CPU interface. Replaces the fixed
//  8x80 simplified stack with a real TOP pointer, tag bits, stack-fault detection and an IDLE/EXEC/DONE handshake.
//  Arithmetic and transcendental opcodes are timed only; their data path is outside this block.
// PARAMETERS
//  DATA_W  80  stack element / operand / result width
//  DEPTH   8   stack entries; power of 2
//  PTR_W   $clog2(DEPTH)  TOP pointer width
//  CYC_W   9   latency counter width; must hold 299
// PORTS
//  clk         in   1       clock
//  reset       in   1       reset, asynchronous, active-high
//  start       in   1       request; sampled only in IDLE
//  op          in   8       ESC opcode byte (D8..DF)
//  modrm       in   8       ModR/M byte
//  operand     in   DATA_W  load data for push operations
//  ctrl_word   in   16      control word; bit0 = IM (invalid mask)
//  ctrl_we     in   1       load ctrl_word
//  busy        out  1       high in EXEC
//  done        out  1       one-cycle completion pulse
//  result      out  DATA_W  store data / status image
//  status      out  16      [15]B [13:11]TOP [9]C1 [7]ES [6]SF [5:0]sticky exceptions
//  error       out  1       unmasked exception on last op; held until next accepted start
//  tags        out  DEPTH   1 = physical slot valid
// BEHAVIOUR
//  - Reset: all outputs 0; TOP=0; tags=0; control=16'h037F; state IDLE; counter 0.
//  - FSM: IDLE -start-> EXEC (cnt=LAT) -cnt==0-> DONE -> IDLE. start while busy or in DONE is ignored.
//  - Timing: start accepted at edge T; busy from T+1; done=1 for one cycle, busy=0 at T+2+LAT. Stack, tags, TOP and result update at T+1.
//  - ST(i) = slot[(TOP+i) mod DEPTH]. Push: TOP-1, write slot, set tag. Pop: clear tag, TOP+1. Pointer wraps modulo DEPTH.
//  - Decode (op,modrm -> action,LAT):
//    D9 mod!=11 /0, DD /0, DB /5 -> push operand (4,4,5).
//    D9 E8 -> +1.0; EB -> pi 4000C90FDAA22168C235; EE and other E8-EF -> +0; push constant (3).
//    D9 /2, DD /2 -> result=ST0 (7). DB /7, DD /3 -> result=ST0, pop (5).
//    DD /7, DF E0 -> result={0,status} (2).
//    DB E3 FINIT -> TOP=0, tags=0, status=0, control=037F (49).
//    D8 /0,/4 69; /1 129; /6 214; D9 FA 119; FE,FF 249; F2,F3 299. Requires ST0 valid; timing only.
//    Any other opcode -> no effect (9).
//  - Overflow: push when target slot is tagged -> no write, TOP unchanged; SF=1, IE=1, C1=1.
//  - Underflow: read/pop/arith with ST0 empty -> result=FFFFC000000000000000 (indefinite), no pop; SF=1, IE=1, C1=0.
//  - error = IE & ~control[0], valid from T+1. ES = OR(exc[5:0] & ~control[5:0]). Exceptions are sticky until FINIT.
//  - status[15] mirrors busy. TOP field shows the post-update value.
//  - ctrl_we and FINIT accepted in the same cycle: FINIT's 037F wins.
//  - Reset asserted mid-EXEC: immediate return to reset state, no done pulse.
// CONFIGURATION
//  - FPU_STACK_MGMT_EN defined: adds DD C0+i FFREE (clear tag of ST(i)), D9 F6 FDECSTP and D9 F7 FINCSTP (TOP -/+1, tags unchanged, C1=0); LAT 2 each.
//  - Undefined: these opcodes fall into the default case: no effect, LAT 9.
// STRUCTURE
//  - Package fpu_seq_pkg: opcode/ModR/M constants, LAT_* latency constants, CONST_ONE/CONST_PI/INDEFINITE, action enum, FSM state enum.
//  - Sub-module fpu_op_decode: combinational (op,modrm) -> {action, latency, constant}. Holds all opcode knowledge.
// TESTING
//  1 reset; FLD operand=4000A000000000000000 -> done at T+6, TOP=7, tags[7]=1; FST -> result=4000A000000000000000.
//  2 9 consecutive FLD1 -> 9th: SF=1, C1=1, error=1, TOP=0, slot 0 unchanged.
//  3 FSTP on empty stack -> result=FFFFC000000000000000, SF=1, C1=0, error=1; repeat with ctrl_word bit0=1 -> error=0.
//  4 FPTAN with ST0 valid -> busy held 300 cycles, done at T+301; start pulse mid-EXEC -> ignored.
//  5 reset at EXEC cycle 50 of FDIV -> no done; all outputs 0; next FLD accepted normally.
//  6 FINIT with ctrl_we in the same cycle -> control=037F, tags=0, TOP=0; with FPU_STACK_MGMT_EN, FFREE ST0 -> tag cleared.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the x87 stack sequencer: opcode and ModR/M
// constants, per-instruction latencies, 80-bit constant images, the decoded
// action enum and the sequencer FSM state enum.
package fpu_seq_pkg;

  localparam int FP_W = 80;

  // ESC opcode bytes
  localparam logic [7:0] OP_D8 = 8'hD8;
  localparam logic [7:0] OP_D9 = 8'hD9;
  localparam logic [7:0] OP_DB = 8'hDB;
  localparam logic [7:0] OP_DD = 8'hDD;
  localparam logic [7:0] OP_DF = 8'hDF;

  // Register-form ModR/M bytes with fixed meaning
  localparam logic [7:0] MRM_FLD1    = 8'hE8;
  localparam logic [7:0] MRM_FLDPI   = 8'hEB;
  localparam logic [7:0] MRM_FINIT   = 8'hE3;
  localparam logic [7:0] MRM_FSTSW   = 8'hE0;
  localparam logic [7:0] MRM_FSQRT   = 8'hFA;
  localparam logic [7:0] MRM_FSIN    = 8'hFE;
  localparam logic [7:0] MRM_FCOS    = 8'hFF;
  localparam logic [7:0] MRM_FPTAN   = 8'hF2;
  localparam logic [7:0] MRM_FPATAN  = 8'hF3;
  localparam logic [7:0] MRM_FDECSTP = 8'hF6;
  localparam logic [7:0] MRM_FINCSTP = 8'hF7;

  // Latencies (EXEC cycles counted down to zero)
  localparam int LAT_FLD_S   = 4;
  localparam int LAT_FLD_E   = 5;
  localparam int LAT_CONST   = 3;
  localparam int LAT_FST     = 7;
  localparam int LAT_FSTP    = 5;
  localparam int LAT_FSTSW   = 2;
  localparam int LAT_FINIT   = 49;
  localparam int LAT_FADD    = 69;
  localparam int LAT_FMUL    = 129;
  localparam int LAT_FDIV    = 214;
  localparam int LAT_FSQRT   = 119;
  localparam int LAT_FSINCOS = 249;
  localparam int LAT_FPTAN   = 299;
  localparam int LAT_STKMGMT = 2;
  localparam int LAT_NONE    = 9;

  localparam logic [FP_W-1:0] CONST_ONE  = 80'h3FFF8000000000000000;
  localparam logic [FP_W-1:0] CONST_PI   = 80'h4000C90FDAA22168C235;
  localparam logic [FP_W-1:0] INDEFINITE = 80'hFFFFC000000000000000;

  localparam logic [15:0] CTRL_RESET = 16'h037F;

  typedef enum logic [3:0] {
    ACT_NONE,
    ACT_PUSH_OPERAND,
    ACT_PUSH_CONST,
    ACT_STORE,
    ACT_STORE_POP,
    ACT_STATUS,
    ACT_FINIT,
    ACT_ARITH,
    ACT_FFREE,
    ACT_DECSTP,
    ACT_INCSTP
  } act_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational opcode decoder: (op, modrm) -> {action, latency, constant}.
// All knowledge of which ESC encodings the sequencer understands lives here.
// Optional feature macro: FPU_STACK_MGMT_EN (FFREE / FDECSTP / FINCSTP).
// Ports:
//   op        in   8       ESC opcode byte
//   modrm     in   8       ModR/M byte
//   action    out  act_t   decoded stack action
//   latency   out  CYC_W   EXEC countdown start value
//   const_val out  DATA_W  constant pushed by the FLD-constant forms
module fpu_op_decode
  import fpu_seq_pkg::*;
#(
  parameter int DATA_W = 80,
  parameter int CYC_W  = 9
) (
  input  logic [7:0]        op,
  input  logic [7:0]        modrm,
  output act_t              action,
  output logic [CYC_W-1:0]  latency,
  output logic [DATA_W-1:0] const_val
);

  logic       is_reg;
  logic [2:0] reg_f;

  assign is_reg = (modrm[7:6] == 2'b11);
  assign reg_f  = modrm[5:3];

  always_comb begin
    action    = ACT_NONE;
    latency   = CYC_W'(LAT_NONE);
    const_val = '0;
    case (op)
      OP_D8: begin
        case (reg_f)
          3'd0, 3'd4: begin action = ACT_ARITH; latency = CYC_W'(LAT_FADD); end
          3'd1:       begin action = ACT_ARITH; latency = CYC_W'(LAT_FMUL); end
          3'd6:       begin action = ACT_ARITH; latency = CYC_W'(LAT_FDIV); end
          default: ;
        endcase
      end
      OP_D9: begin
        if (!is_reg) begin
          if (reg_f == 3'd0) begin
            action = ACT_PUSH_OPERAND; latency = CYC_W'(LAT_FLD_S);
          end else if (reg_f == 3'd2) begin
            action = ACT_STORE; latency = CYC_W'(LAT_FST);
          end
        end else if (modrm[7:3] == 5'b11101) begin
          // E8..EF: only FLD1 and FLDPI carry non-zero images here
          action  = ACT_PUSH_CONST;
          latency = CYC_W'(LAT_CONST);
          if (modrm == MRM_FLD1)       const_val = DATA_W'(CONST_ONE);
          else if (modrm == MRM_FLDPI) const_val = DATA_W'(CONST_PI);
        end else begin
          case (modrm)
            MRM_FSQRT:             begin action = ACT_ARITH; latency = CYC_W'(LAT_FSQRT); end
            MRM_FSIN, MRM_FCOS:    begin action = ACT_ARITH; latency = CYC_W'(LAT_FSINCOS); end
            MRM_FPTAN, MRM_FPATAN: begin action = ACT_ARITH; latency = CYC_W'(LAT_FPTAN); end
`ifdef FPU_STACK_MGMT_EN
            MRM_FDECSTP:           begin action = ACT_DECSTP; latency = CYC_W'(LAT_STKMGMT); end
            MRM_FINCSTP:           begin action = ACT_INCSTP; latency = CYC_W'(LAT_STKMGMT); end
`endif
            default: ;
          endcase
        end
      end
      OP_DB: begin
        if (!is_reg && reg_f == 3'd5) begin
          action = ACT_PUSH_OPERAND; latency = CYC_W'(LAT_FLD_E);
        end else if (!is_reg && reg_f == 3'd7) begin
          action = ACT_STORE_POP; latency = CYC_W'(LAT_FSTP);
        end else if (modrm == MRM_FINIT) begin
          action = ACT_FINIT; latency = CYC_W'(LAT_FINIT);
        end
      end
      OP_DD: begin
        if (!is_reg) begin
          case (reg_f)
            3'd0: begin action = ACT_PUSH_OPERAND; latency = CYC_W'(LAT_FLD_S); end
            3'd2: begin action = ACT_STORE;        latency = CYC_W'(LAT_FST);   end
            3'd3: begin action = ACT_STORE_POP;    latency = CYC_W'(LAT_FSTP);  end
            3'd7: begin action = ACT_STATUS;       latency = CYC_W'(LAT_FSTSW); end
            default: ;
          endcase
        end
`ifdef FPU_STACK_MGMT_EN
        else if (reg_f == 3'd0) begin
          action = ACT_FFREE; latency = CYC_W'(LAT_STKMGMT);
        end
`endif
      end
      OP_DF: begin
        if (modrm == MRM_FSTSW) begin
          action = ACT_STATUS; latency = CYC_W'(LAT_FSTSW);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fpu_stack_sequencer.sv
// x87 register-stack and timing model behind the FPU CPU interface.
// Keeps a TOP pointer, per-slot tag bits, sticky exceptions and stack-fault
// detection; arithmetic/transcendental opcodes are timed only.
// Optional feature macro: FPU_STACK_MGMT_EN (FFREE / FDECSTP / FINCSTP).
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               request, sampled only when idle
//   op, modrm           ESC opcode byte and ModR/M byte
//   operand             load data for push operations
//   ctrl_word, ctrl_we  control word and its load strobe (bit0 = IM)
//   busy                high while executing
//   done                one-cycle completion pulse
//   result              store data / status image
//   status              [15]B [13:11]TOP [9]C1 [7]ES [6]SF [5:0]exceptions
//   error               unmasked exception on last op
//   tags                1 = physical slot valid
//
// Handshake: start is accepted on an edge where the FSM is idle and no done
// pulse is showing; op/modrm/operand are captured on that edge. busy rises
// one cycle later and stays high LAT+1 cycles; done pulses for one cycle
// as busy falls. start is ignored at all other times.
module fpu_stack_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CYC_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        op,
  input  logic [7:0]        modrm,
  input  logic [DATA_W-1:0] operand,
  input  logic [15:0]       ctrl_word,
  input  logic              ctrl_we,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [15:0]       status,
  output logic              error,
  output logic [DEPTH-1:0]  tags
);

  state_t             state;
  logic [CYC_W-1:0]   cnt;
  logic               first;
  act_t               act_q;
  logic [DATA_W-1:0]  const_q;
  logic [DATA_W-1:0]  operand_q;
  logic [PTR_W-1:0]   top;
  logic [15:0]        control;
  logic               sf;
  logic               c1;
  logic [5:0]         exc;
  logic [DATA_W-1:0]  slots [DEPTH];
`ifdef FPU_STACK_MGMT_EN
  logic [PTR_W-1:0]   sti_q;
`endif

  act_t               dec_act;
  logic [CYC_W-1:0]   dec_lat;
  logic [DATA_W-1:0]  dec_const;

  fpu_op_decode #(.DATA_W(DATA_W), .CYC_W(CYC_W)) u_decode (
    .op        (op),
    .modrm     (modrm),
    .action    (dec_act),
    .latency   (dec_lat),
    .const_val (dec_const)
  );

  logic [PTR_W-1:0]  top_dec;
  logic [PTR_W-1:0]  top_inc;
  logic              exec_now;
  logic              is_push;
  logic              push_full;
  logic              st0_valid;
  logic [DATA_W-1:0] push_data;
  logic              es;
  logic [2:0]        top_field;

  assign top_dec   = top - PTR_W'(1);
  assign top_inc   = top + PTR_W'(1);
  // The stack effect happens exactly once, on the first EXEC edge.
  assign exec_now  = (state == ST_EXEC) && first;
  assign is_push   = (act_q == ACT_PUSH_OPERAND) || (act_q == ACT_PUSH_CONST);
  assign push_full = tags[top_dec];
  assign st0_valid = tags[top];
  assign push_data = (act_q == ACT_PUSH_OPERAND) ? operand_q : const_q;
  assign es        = |(exc & ~control[5:0]);
  assign top_field = 3'(top);
  assign status    = {busy, 1'b0, top_field, 1'b0, c1, 1'b0, es, sf, exc};

  // Slot storage carries no reset; validity is tracked by tags.
  always_ff @(posedge clk) begin
    if (exec_now && is_push && !push_full) slots[top_dec] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      first     <= 1'b0;
      act_q     <= ACT_NONE;
      const_q   <= '0;
      operand_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      error     <= 1'b0;
      tags      <= '0;
      top       <= '0;
      control   <= CTRL_RESET;
      sf        <= 1'b0;
      c1        <= 1'b0;
      exc       <= '0;
`ifdef FPU_STACK_MGMT_EN
      sti_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (ctrl_we) control <= ctrl_word;

      case (state)
        ST_IDLE: begin
          if (start && !done) begin
            state     <= ST_EXEC;
            cnt       <= dec_lat;
            act_q     <= dec_act;
            const_q   <= dec_const;
            operand_q <= operand;
            first     <= 1'b1;
            error     <= 1'b0;
`ifdef FPU_STACK_MGMT_EN
            sti_q     <= PTR_W'(modrm[2:0]);
`endif
          end
        end

        ST_EXEC: begin
          busy  <= 1'b1;
          first <= 1'b0;
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - CYC_W'(1);

          if (exec_now) begin
            case (act_q)
              ACT_PUSH_OPERAND, ACT_PUSH_CONST: begin
                if (push_full) begin
                  // Overflow: target slot still occupied, stack untouched.
                  sf     <= 1'b1;
                  exc[0] <= 1'b1;
                  c1     <= 1'b1;
                  error  <= ~control[0];
                end else begin
                  top           <= top_dec;
                  tags[top_dec] <= 1'b1;
                end
              end
              ACT_STORE, ACT_STORE_POP, ACT_ARITH: begin
                if (!st0_valid) begin
                  // Underflow: deliver the indefinite NaN and never pop.
                  result <= DATA_W'(INDEFINITE);
                  sf     <= 1'b1;
                  exc[0] <= 1'b1;
                  c1     <= 1'b0;
                  error  <= ~control[0];
                end else if (act_q != ACT_ARITH) begin
                  result <= slots[top];
                  if (act_q == ACT_STORE_POP) begin
                    tags[top] <= 1'b0;
                    top       <= top_inc;
                  end
                end
              end
              ACT_STATUS: result <= DATA_W'(status);
              ACT_FINIT: begin
                // Placed after the ctrl_we load so FINIT wins a same-edge write.
                top     <= '0;
                tags    <= '0;
                sf      <= 1'b0;
                c1      <= 1'b0;
                exc     <= '0;
                control <= CTRL_RESET;
              end
`ifdef FPU_STACK_MGMT_EN
              ACT_FFREE:  tags[top + sti_q] <= 1'b0;
              ACT_DECSTP: begin top <= top_dec; c1 <= 1'b0; end
              ACT_INCSTP: begin top <= top_inc; c1 <= 1'b0; end
`endif
              default: ;
            endcase
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
